// File: rtl/whack_pkg.sv
// whack_pkg: shared state encoding and box/retry constants for the whack game.
package whack_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARMED, S_RESULT, S_GAME_OVER} state_t;
    localparam logic [2:0] BOX_NONE = 3'd0;
    localparam logic [2:0] BOX_MIN = 3'd1;
    localparam logic [2:0] BOX_MAX = 3'd4;
    localparam logic [1:0] RETRY_LIMIT = 2'd3;
endpackage

// File: rtl/whack_timer.sv
// whack_timer: loadable up-counter with clear that stops at a selectable terminal count.
module whack_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic [W-1:0] i_limit,
    output logic         o_tc
);
    logic [W-1:0] r_count;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_count <= '0;
        else if (i_clr) r_count <= '0;
        else if (i_load) r_count <= i_load_val;
        else if (i_en && !o_tc) r_count <= r_count + 1'b1;
    end
    assign o_tc = r_count == i_limit;
endmodule

// File: rtl/whack_judge.sv
// whack_judge: arms a target from the generator, judges whacks against it, and keeps score/misses.
module whack_judge
    import whack_pkg::*;
#(
    parameter int WINDOW_CYCLES = 50_000_000,
    parameter int GAP_CYCLES = 12_500_000,
    parameter int MAX_MISSES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] target_in,
    input  logic       hit_valid,
    input  logic [2:0] hit_box,
    output logic [2:0] active_box,
    output logic [7:0] score,
    output logic [3:0] misses,
    output logic       result_hit,
    output logic       result_miss,
    output logic       game_over
);
    localparam int MAXC = WINDOW_CYCLES > GAP_CYCLES ? WINDOW_CYCLES : GAP_CYCLES;
    localparam int TW = MAXC > 1 ? $clog2(MAXC) : 1;
    state_t r_state, w_next;
    logic [2:0] r_active, r_prev;
    logic [7:0] r_score;
    logic [3:0] r_misses, w_misses_nxt;
    logic [1:0] r_retry;
    logic r_result_hit, r_result_miss, r_game_over;
    logic w_tc, w_armed, w_idle, w_tgt_ok, w_retry, w_accept, w_hit, w_miss, w_result;
    assign w_armed = r_state == S_ARMED;
    assign w_idle = r_state == S_IDLE || r_state == S_GAME_OVER;
    assign w_tgt_ok = target_in >= BOX_MIN && target_in <= BOX_MAX;
    assign w_retry = target_in == r_prev && r_retry < RETRY_LIMIT;
    assign w_accept = r_state == S_LOAD && w_tgt_ok && !w_retry;
    // Correct hit outranks both a wrong box and a timeout on the same edge
    assign w_hit = w_armed && hit_valid && hit_box == r_active;
    assign w_miss = w_armed && !w_hit && (hit_valid || w_tc);
    assign w_result = w_hit || w_miss;
    assign w_misses_nxt = r_misses + 4'd1;
    whack_timer #(.W(TW)) u_timer (
        .clk(clk),
        .reset(reset),
        .i_clr(!(w_armed || r_state == S_RESULT) || w_result),
        .i_en(1'b1),
        .i_load(1'b0),
        .i_load_val('0),
        .i_limit(w_armed ? TW'(WINDOW_CYCLES - 1) : TW'(GAP_CYCLES - 1)),
        .o_tc(w_tc)
    );
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_GAME_OVER: w_next = start ? S_LOAD : r_state;
            S_LOAD: w_next = w_accept ? S_ARMED : S_LOAD;
            S_ARMED: w_next = !w_result ? S_ARMED : (w_miss && w_misses_nxt == 4'(MAX_MISSES)) ? S_GAME_OVER : S_RESULT;
            S_RESULT: w_next = w_tc ? S_LOAD : S_RESULT;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_active <= BOX_NONE;
            r_prev <= BOX_NONE;
            r_score <= '0;
            r_misses <= '0;
            r_retry <= '0;
            r_result_hit <= 1'b0;
            r_result_miss <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state <= w_next;
            r_result_hit <= w_hit;
            r_result_miss <= w_miss;
            r_game_over <= w_next == S_GAME_OVER;
            if (w_idle && start) begin
                r_score <= '0;
                r_misses <= '0;
            end
            if (r_state == S_LOAD && w_tgt_ok && w_retry) r_retry <= r_retry + 2'd1;
            if (w_accept) begin
                r_active <= target_in;
                r_prev <= target_in;
                r_retry <= '0;
            end
            if (w_hit && r_score != 8'hFF) r_score <= r_score + 8'd1;
            if (w_miss) r_misses <= w_misses_nxt;
            if (w_result) r_active <= BOX_NONE;
        end
    end
    assign active_box = r_active;
    assign score = r_score;
    assign misses = r_misses;
    assign result_hit = r_result_hit;
    assign result_miss = r_result_miss;
    assign game_over = r_game_over;
endmodule
